sourcechannel_tx: RTL and testbench
===================================

// Module: sourcechannel_tx
// PURPOSE
//  Transmitter end of the source channel: buffers locally produced (priority, data) requests
//  and drives them onto the channel_valid/channel_ready/channel_priority/channel_data handshake
//  toward the priority arbiter. A head request stalled by channel_ready has its priority aged
//  upward (anti-starvation) until accepted. One instance per source channel.
// PARAMETERS
//  SDATA_W     8   data width of source channel
//  PRIORITY_W  8   priority width; all-ones is the highest priority
//  DEPTH       4   buffer entries; power of 2, >= 2
//  AGE_THRESH  16  stalled head cycles per +1 priority boost; >= 1
// PORTS
//  clk               in   1                   single clock, all logic on posedge
//  rst               in   1                   asynchronous, active-high reset
//  wr_valid          in   1                   local producer offers a request
//  wr_ready          out  1                   buffer accepts the request this cycle
//  wr_priority       in   PRIORITY_W          initial priority of offered request
//  wr_data           in   SDATA_W             payload of offered request
//  channel_valid     out  1                   head request presented to arbiter
//  channel_ready     in   1                   arbiter accepts head this cycle
//  channel_priority  out  PRIORITY_W          current (aged) priority of head
//  channel_data      out  SDATA_W             payload of head
//  level             out  $clog2(DEPTH+1)     entries currently held
//  boost             out  1                   1-cycle pulse: head priority incremented
// BEHAVIOUR
//  Reset (async assert, sync release): wr/rd pointers, level, age counter = 0;
//   channel_valid=0, boost=0, wr_ready=0 while rst high, then 1. Storage array not reset.
//  Push = wr_valid & wr_ready; wr_ready = ~rst & (level != DEPTH). No full-bypass: when full,
//   wr_ready=0 even if the head pops in the same cycle.
//  Pop = channel_valid & channel_ready; channel_valid = (level != 0). No empty-bypass: a push
//   into an empty buffer appears on the channel the following cycle (latency 1).
//  Push+pop in the same cycle: level unchanged, both pointers advance. Pointers wrap modulo DEPTH.
//  channel_data is held stable while channel_valid & ~channel_ready. channel_priority
//   changes only through aging. The arbiter samples both values on the pop cycle.
//  Aging FSM (2 states, per head):
//   IDLE  : level==0, or head accepted this cycle; age_cnt=0. -> WAIT when level!=0 & no pop.
//   WAIT  : each cycle with channel_valid & ~channel_ready: age_cnt++.
//           When age_cnt==AGE_THRESH-1 on such a cycle:
//             - head.priority = sat(head.priority+1), capped at 2^PRIORITY_W-1;
//             - boost=1 for that cycle, age_cnt=0.
//           Pop -> age_cnt=0; the next head starts fresh (no inherited age).
//  At max priority: no further increment and boost stays 0, but age_cnt keeps wrapping.
//  Aging rewrites only the head entry. Queued entries keep their pushed priority.
//  Reset mid-transfer: all queued requests are discarded; no handshake completes in reset cycles.
// STRUCTURE
//  Package sourcechannel_pkg:
//   - SDATA_W, PRIORITY_W localparams;
//   - typedef struct packed {logic [PRIORITY_W-1:0] prio; logic [SDATA_W-1:0] data;} src_req_t.
//  Sub-module sourcechannel_fifo:
//   - src_req_t storage, pointers, level;
//   - head read port plus a head-priority write port for aging.
//  Aging counter/FSM and handshake glue live in the top.
// TESTING
//  1. Reset release: push p=0x10 d=0xA5 -> next cycle channel_valid=1, prio=0x10, data=0xA5;
//     ready=1 -> valid=0.
//  2. Fill 4 entries with channel_ready=0 -> level=4, wr_ready=0.
//     A 5th push with ready=1 the same cycle is refused.
//     Pops return entries in push order.
//  3. AGE_THRESH=16, head p=0x10, ready=0 for 40 cycles -> boost on stall cycles 16 and 32;
//     prio 0x11 then 0x12; data unchanged throughout.
//  4. Head p=0xFE stalled 48 cycles -> one boost to 0xFF, then no further boost, prio stays 0xFF.
//  5. Simultaneous push+pop at level=2 for 10 cycles -> level stays 2, FIFO order preserved
//     across pointer wrap.
//  6. Assert rst with level=3 mid-stall -> channel_valid=0, level=0 immediately;
//     after release the first push re-appears with its original priority.

Source files
------------

// File: rtl/sourcechannel_pkg.sv
// sourcechannel_pkg: request type, widths and priority helpers shared by the source channel transmitter.
package sourcechannel_pkg;
  localparam int SDATA_W = 8;
  localparam int PRIORITY_W = 8;
  localparam logic [PRIORITY_W-1:0] PRIO_MAX = '1;
  typedef struct packed {
    logic [PRIORITY_W-1:0] prio;
    logic [SDATA_W-1:0]    data;
  } src_req_t;
  typedef enum logic {IDLE, WAIT} age_state_t;
  function automatic logic [PRIORITY_W-1:0] sat_inc(input logic [PRIORITY_W-1:0] p);
    return (p == PRIO_MAX) ? p : p + 1'b1;
  endfunction
endpackage

// File: rtl/sourcechannel_if.sv
// sourcechannel_if: producer write port and arbiter-facing channel handshake.
interface sourcechannel_if;
  import sourcechannel_pkg::*;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [PRIORITY_W-1:0] wr_priority;
  logic [SDATA_W-1:0]    wr_data;
  logic                  channel_valid;
  logic                  channel_ready;
  logic [PRIORITY_W-1:0] channel_priority;
  logic [SDATA_W-1:0]    channel_data;
  modport master (
    output wr_valid, wr_priority, wr_data, channel_ready,
    input  wr_ready, channel_valid, channel_priority, channel_data
  );
  modport slave (
    input  wr_valid, wr_priority, wr_data, channel_ready,
    output wr_ready, channel_valid, channel_priority, channel_data
  );
endinterface

// File: rtl/sourcechannel_fifo.sv
// sourcechannel_fifo: request buffer with a head read port and a head-priority rewrite port.
module sourcechannel_fifo
  import sourcechannel_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  src_req_t              wr_req,
  output src_req_t              head,
  input  logic                  prio_we,
  input  logic [PRIORITY_W-1:0] prio_wd,
  output logic [LW-1:0]         level
);
  src_req_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  // A head rewrite never collides with a push: rd_ptr==wr_ptr with entries held means full.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_req;
    if (prio_we) mem[rd_ptr].prio <= prio_wd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level  <= (push & ~pop) ? level + 1'b1 : (pop & ~push) ? level - 1'b1 : level;
    end
  end
endmodule

// File: rtl/sourcechannel_tx.sv
// sourcechannel_tx: buffers local requests and presents them to the arbiter, aging a stalled head's priority.
module sourcechannel_tx
  import sourcechannel_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AGE_THRESH = 16,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int CW = (AGE_THRESH > 1) ? $clog2(AGE_THRESH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  sourcechannel_if.slave ch,
  output logic [LW-1:0] level,
  output logic          boost
);
  src_req_t   head;
  age_state_t state;
  logic [CW-1:0] age_cnt, age;
  logic push, pop, stall, hit;
  assign ch.wr_ready         = ~rst & (level != LW'(DEPTH));
  assign ch.channel_valid    = level != '0;
  assign ch.channel_priority = head.prio;
  assign ch.channel_data     = head.data;
  assign push  = ch.wr_valid & ch.wr_ready;
  assign pop   = ch.channel_valid & ch.channel_ready;
  assign stall = ch.channel_valid & ~ch.channel_ready;
  // IDLE guarantees a fresh count for a new head.
  assign age   = (state == WAIT) ? age_cnt : '0;
  assign hit   = stall & (age == CW'(AGE_THRESH - 1));
  assign boost = hit & (head.prio != PRIO_MAX);
  sourcechannel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_req  ('{prio: ch.wr_priority, data: ch.wr_data}),
    .head    (head),
    .prio_we (hit),
    .prio_wd (sat_inc(head.prio)),
    .level   (level)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      age_cnt <= '0;
    end else begin
      state   <= stall ? WAIT : IDLE;
      age_cnt <= (stall & ~hit) ? age + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_sourcechannel_tx.sv
// tb_sourcechannel_tx: queue-model scoreboard for the source channel transmitter under directed and random traffic.
module tb_sourcechannel_tx;
  import sourcechannel_pkg::*;
  localparam int DEPTH = 4;
  localparam int T = 16;
  logic clk = 0;
  logic rst;
  logic [2:0] level;
  logic boost;
  sourcechannel_if bus ();
  sourcechannel_tx #(.DEPTH(DEPTH), .AGE_THRESH(T)) dut (
    .clk   (clk),
    .rst   (rst),
    .ch    (bus),
    .level (level),
    .boost (boost)
  );
  always #5 clk = ~clk;
  src_req_t q[$];
  int n, sz, checks, failures;
  bit eb;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", int'(bus.channel_valid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_wr_ready", int'(bus.wr_ready), 0);
      chk("rst_boost", int'(boost), 0);
      q.delete();
      n = 0;
    end else begin
      sz = q.size();
      chk("level", int'(level), sz);
      chk("channel_valid", int'(bus.channel_valid), int'(sz != 0));
      chk("wr_ready", int'(bus.wr_ready), int'(sz != DEPTH));
      if (sz != 0) begin
        chk("head_prio", int'(bus.channel_priority), int'(q[0].prio));
        chk("head_data", int'(bus.channel_data), int'(q[0].data));
      end
      eb = 0;
      if (sz != 0 && !bus.channel_ready) begin
        n++;
        eb = (n % T == 0) && (q[0].prio != 8'hFF);
      end
      chk("boost", int'(boost), int'(eb));
      if (eb) q[0].prio = q[0].prio + 8'd1;
      if (sz != 0 && bus.channel_ready) begin
        void'(q.pop_front());
        n = 0;
      end
      if (bus.wr_valid && sz != DEPTH) q.push_back('{prio: bus.wr_priority, data: bus.wr_data});
    end
  end
  task automatic cyc(input bit wv, input logic [7:0] p, input logic [7:0] d, input bit rdy);
    @(posedge clk);
    #1;
    bus.wr_valid = wv;
    bus.wr_priority = p;
    bus.wr_data = d;
    bus.channel_ready = rdy;
  endtask
  task automatic idle(input int k, input bit rdy);
    repeat (k) cyc(0, 8'h00, 8'h00, rdy);
  endtask
  initial begin
    rst = 1;
    bus.wr_valid = 0;
    bus.wr_priority = '0;
    bus.wr_data = '0;
    bus.channel_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cyc(1, 8'h10, 8'hA5, 0);
    idle(1, 0);
    idle(1, 1);
    idle(2, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'($urandom), 8'($urandom), 0);
    cyc(1, 8'h77, 8'h88, 1);
    idle(4, 1);
    idle(1, 0);
    cyc(1, 8'h10, 8'h3C, 0);
    idle(40, 0);
    idle(2, 1);
    cyc(1, 8'hFE, 8'h5A, 0);
    idle(48, 0);
    idle(2, 1);
    cyc(1, 8'h01, 8'h11, 0);
    cyc(1, 8'h02, 8'h22, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 8'($urandom), 1);
    idle(3, 1);
    for (int i = 0; i < 3; i++) cyc(1, 8'h40 + 8'(i), 8'hC0 + 8'(i), 0);
    idle(5, 0);
    @(posedge clk);
    #3 rst = 1;
    bus.wr_valid = 1;
    bus.channel_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    bus.wr_valid = 0;
    bus.channel_ready = 0;
    cyc(1, 8'h33, 8'h44, 0);
    idle(3, 0);
    idle(2, 1);
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), 8'($urandom),
          $urandom_range(0, 29) == 0);
    idle(6, 1);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
